tdp_ram_ctrl: RTL
=================

Name: tdp_ram_ctrl

Overview:
Single-clock true dual-port RAM. It is the parametrised successor to the team's two-port RAM and adds:
- per-byte write enables
- selectable read latency
- defined same-address collision and read-during-write semantics
- a sequenced memory-clear engine in place of the single-cycle array reset

It sits behind the AXI slave datapath as the shared storage for two independent requesters (A = AXI side, B = local engine).

Parameters:
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width; must be a multiple of 8
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 0, cross-port read of an address written the same cycle: 0 = read-first (old data), 1 = write-first (new data)

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
init_req  in  1  one-cycle pulse requesting a full memory clear
busy  out  1  high while the clear engine runs; port requests are ignored
en_a  in  1  port A request valid
we_a  in  DATA_WIDTH/8  port A byte write enables; all zero means read
addr_a  in  ADDR_WIDTH  port A address
din_a  in  DATA_WIDTH  port A write data
dout_a  out  DATA_WIDTH  port A read data
dvalid_a  out  1  port A read data valid pulse
en_b, we_b, addr_b, din_b, dout_b, dvalid_b: port B, same widths and meaning as port A
collision  out  1  pulse: both ports accessed the same address in one cycle with at least one write

Behaviour:
- Async reset (rst_n low):
  - busy=1 and clear state set immediately.
  - dout_a, dout_b, dvalid_a, dvalid_b, collision all 0.
  - Memory array is not reset asynchronously.
- Clear FSM, states IDLE and CLEAR:
  - After rst_n rises, the FSM is in CLEAR with counter = 0.
  - CLEAR writes 0 to address counter, one word per cycle. It moves to IDLE after address DEPTH-1, so the clear takes exactly DEPTH cycles.
  - busy=1 throughout CLEAR and falls on the first IDLE cycle.
  - init_req in IDLE enters CLEAR with counter = 0 on the next cycle. init_req during CLEAR is ignored.
  - Reset asserted mid-clear restarts the clear from address 0 after release.
- While busy=1: en_a/en_b are ignored, no writes occur, dvalid stays 0, dout holds.
- Accepted request: en_x=1 and busy=0.
- Write: each byte lane i with we_x[i]=1 updates mem[addr_x][8i+7:8i] at the clock edge. No read is performed and dvalid_x is not asserted.
- Read (we_x all zero):
  - dout_x is updated and dvalid_x pulses high for one cycle, RD_LATENCY cycles after acceptance.
  - With RD_LATENCY=2 the second stage is a plain register.
  - Back-to-back reads give one result per cycle.
  - dout_x holds its last value when not updated.
- Same address, both ports write: per byte lane, port A wins where both enable. Port B bytes are written where only B enables.
- Same address, one port reads while the other writes:
  - RDW_MODE=0: the reader returns pre-write data.
  - RDW_MODE=1: the reader returns the merged post-write word (byte-wise).
- Same address, both ports read: no conflict; both return identical data.
- collision pulses one cycle after any same-address accepted pair where at least one port writes. Never asserted for read/read.
- Different addresses: fully independent, no stalls.

Optional Feature:
Macro: TDP_RAM_PARITY_EN.
- Defined:
  - Each byte is stored with an even-parity bit; the clear engine writes parity 0.
  - Reads check parity. Extra outputs perr_a/perr_b (1 bit each) are aligned with dvalid_x and are high if any byte of the word mismatches.
  - Reset value 0.
- Undefined: no parity storage, no perr ports; behaviour otherwise identical.

Decomposition:
- Package tdp_ram_pkg holds:
  - the clear FSM state enum (ST_IDLE, ST_CLEAR)
  - localparam BYTE_W = 8
  - the function computing the byte-merged write word (lane-wise select of old/new data under a byte-enable mask)
  - the function computing even parity per byte
- One sub-module, tdp_ram_rd_pipe: the RD_LATENCY 1/2 data+valid delay stage, instantiated once per port.

Test Plan:
- Release rst_n, ADDR_WIDTH=4 -> busy=1 for exactly 16 cycles, then 0. Read all addresses -> 0x00000000, each dvalid one pulse RD_LATENCY cycles after request.
- Write A addr 3 din 0xAABBCCDD we 0xF, then we 0x2 din 0x00001100 -> read addr 3 returns 0xAABB11DD.
- Same cycle: A writes 0x11111111 we 0x3 and B writes 0x22222222 we 0xE to addr 5 -> mem[5]=0x22221111, collision pulses 1 cycle later.
- Addr 7 holds 0x0; A writes 0xDEADBEEF we 0xF while B reads addr 7 -> B gets 0x00000000 (RDW_MODE=0) or 0xDEADBEEF (RDW_MODE=1); collision=1.
- Pulse init_req after filling memory. Issue A/B requests during busy -> ignored, dvalid stays 0. After 16 cycles all reads return 0. Assert rst_n low mid-clear -> outputs 0 immediately, full 16-cycle clear after release.
- With TDP_RAM_PARITY_EN, force one stored parity bit flipped at addr 2 -> read addr 2 gives perr_a=1 aligned with dvalid_a; other addresses give perr_a=0.

Source files
------------

// File: rtl/tdp_ram_pkg.sv
// Shared types and helpers for the tdp_ram_ctrl true dual-port RAM.
// Helpers operate on a fixed maximum width; callers size-cast in and out.
package tdp_ram_pkg;

  localparam int BYTE_W = 8;
  localparam int MAX_DW = 512;
  localparam int MAX_NB = MAX_DW / BYTE_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Lane-wise select: lanes with be set take new_w, others keep old_w.
  function automatic logic [MAX_DW-1:0] merge_bytes(input logic [MAX_DW-1:0] old_w,
                                                    input logic [MAX_DW-1:0] new_w,
                                                    input logic [MAX_NB-1:0] be);
    logic [MAX_DW-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_NB; i++) begin
      if (be[i]) r[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    end
    return r;
  endfunction

  // Even parity bit per byte: the bit that makes the byte+parity ones-count even.
  function automatic logic [MAX_NB-1:0] byte_parity(input logic [MAX_DW-1:0] w);
    logic [MAX_NB-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_NB; i++) begin
      p[i] = ^w[i*BYTE_W +: BYTE_W];
    end
    return p;
  endfunction

endpackage

// File: rtl/tdp_ram_rd_pipe.sv
// Read-data delay stage for one tdp_ram_ctrl port: RD_LATENCY 1 or 2 cycles.
// Output data holds its last value whenever no read result arrives.
module tdp_ram_rd_pipe #(
  parameter int WIDTH      = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             stg_valid;
  logic [WIDTH-1:0] stg_data;

  if (RD_LATENCY >= 2) begin : g_two_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg_valid <= 1'b0;
        stg_data  <= '0;
      end else begin
        stg_valid <= in_valid;
        if (in_valid) stg_data <= in_data;
      end
    end
  end else begin : g_one_stage
    assign stg_valid = in_valid;
    assign stg_data  = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= stg_valid;
      if (stg_valid) out_data <= stg_data;
    end
  end

endmodule

// File: rtl/tdp_ram_ctrl.sv
// Single-clock true dual-port RAM with byte enables, RD_LATENCY 1/2, defined
// collision semantics and a sequenced clear engine. Optional: TDP_RAM_PARITY_EN.
module tdp_ram_ctrl
  import tdp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_req,
  output logic                    busy,
  input  logic                    en_a,
  input  logic [DATA_WIDTH/8-1:0] we_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   din_a,
  output logic [DATA_WIDTH-1:0]   dout_a,
  output logic                    dvalid_a,
  input  logic                    en_b,
  input  logic [DATA_WIDTH/8-1:0] we_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   din_b,
  output logic [DATA_WIDTH-1:0]   dout_b,
  output logic                    dvalid_b,
`ifdef TDP_RAM_PARITY_EN
  output logic                    perr_a,
  output logic                    perr_b,
`endif
  output logic                    collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / BYTE_W;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
`ifdef TDP_RAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int PW = DATA_WIDTH + PAR_W;

  clr_state_e            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------- clear FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          if (init_req) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign busy = (state == ST_CLEAR);

  // ------------------------------------------------------- request decoding
  logic acc_a, acc_b, wr_a, wr_b, rd_a, rd_b, same_addr;

  assign acc_a     = en_a && !busy;
  assign acc_b     = en_b && !busy;
  assign wr_a      = acc_a && (we_a != '0);
  assign wr_b      = acc_b && (we_b != '0);
  assign rd_a      = acc_a && (we_a == '0);
  assign rd_b      = acc_b && (we_b == '0);
  assign same_addr = (addr_a == addr_b);

  // Port A merges on top of port B's result so A wins shared lanes and
  // B-only lanes survive; a single array write per address per cycle.
  logic [DATA_WIDTH-1:0] old_a, old_b, base_a, wdata_a, wdata_b;
  logic                  fwd_to_a, fwd_to_b;

  assign old_a   = mem[addr_a];
  assign old_b   = mem[addr_b];
  assign wdata_b = DATA_WIDTH'(merge_bytes(MAX_DW'(old_b), MAX_DW'(din_b), MAX_NB'(we_b)));
  assign base_a  = (same_addr && wr_b) ? wdata_b : old_a;
  assign wdata_a = DATA_WIDTH'(merge_bytes(MAX_DW'(base_a), MAX_DW'(din_a), MAX_NB'(we_a)));

  // Write-first mode hands the reader the other port's merged word.
  assign fwd_to_a = (RDW_MODE != 0) && same_addr && wr_b;
  assign fwd_to_b = (RDW_MODE != 0) && same_addr && wr_a;

  logic [DATA_WIDTH-1:0] rword_a, rword_b;

  assign rword_a = fwd_to_a ? wdata_b : old_a;
  assign rword_b = fwd_to_b ? wdata_a : old_b;

  // NOTE: the array has no reset branch; clearing is done by the clear engine,
  // one word per cycle, so the storage can map onto real RAM.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (wr_b) mem[addr_b] <= wdata_b;
      if (wr_a) mem[addr_a] <= wdata_a;
    end
  end

`ifdef TDP_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] npar_a, npar_b, wpar_a, wpar_b, basepar_a, rpar_a, rpar_b;
  logic          perr_in_a, perr_in_b;

  assign npar_a    = NB'(byte_parity(MAX_DW'(din_a)));
  assign npar_b    = NB'(byte_parity(MAX_DW'(din_b)));
  assign wpar_b    = (npar_b & we_b) | (par_mem[addr_b] & ~we_b);
  assign basepar_a = (same_addr && wr_b) ? wpar_b : par_mem[addr_a];
  assign wpar_a    = (npar_a & we_a) | (basepar_a & ~we_a);
  assign rpar_a    = fwd_to_a ? wpar_b : par_mem[addr_a];
  assign rpar_b    = fwd_to_b ? wpar_a : par_mem[addr_b];
  assign perr_in_a = |(NB'(byte_parity(MAX_DW'(rword_a))) ^ rpar_a);
  assign perr_in_b = |(NB'(byte_parity(MAX_DW'(rword_b))) ^ rpar_b);

  always_ff @(posedge clk) begin
    if (busy) begin
      par_mem[clr_cnt] <= '0;
    end else begin
      if (wr_b) par_mem[addr_b] <= wpar_b;
      if (wr_a) par_mem[addr_a] <= wpar_a;
    end
  end
`endif

  // ------------------------------------------------------------- read paths
  logic [PW-1:0] pin_a, pin_b, pout_a, pout_b;

`ifdef TDP_RAM_PARITY_EN
  assign pin_a            = {perr_in_a, rword_a};
  assign pin_b            = {perr_in_b, rword_b};
  assign {perr_a, dout_a} = pout_a;
  assign {perr_b, dout_b} = pout_b;
`else
  assign pin_a  = rword_a;
  assign pin_b  = rword_b;
  assign dout_a = pout_a;
  assign dout_b = pout_b;
`endif

  tdp_ram_rd_pipe #(.WIDTH(PW), .RD_LATENCY(RD_LATENCY)) u_pipe_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_a),
    .in_data   (pin_a),
    .out_valid (dvalid_a),
    .out_data  (pout_a)
  );

  tdp_ram_rd_pipe #(.WIDTH(PW), .RD_LATENCY(RD_LATENCY)) u_pipe_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_b),
    .in_data   (pin_b),
    .out_valid (dvalid_b),
    .out_data  (pout_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision <= 1'b0;
    else        collision <= acc_a && acc_b && same_addr && (wr_a || wr_b);
  end

endmodule
